// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the instruction-fetch and data ports.
// One transaction in flight, data-first priority with a fetch anti-starvation counter.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FAIR_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_busy,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_valid,
  output logic                dm_busy,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(FAIR_LIMIT + 1);
  localparam logic [CNT_W-1:0] FAIR_MAX = CNT_W'(FAIR_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state_reg, state_next;
  logic                owner_reg, owner_next;  // 1 = data port owns the transaction
  logic                mem_req_reg, mem_req_next;
  logic                mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
  logic [STRB_W-1:0]   mem_wstrb_reg, mem_wstrb_next;
  logic                if_valid_reg, if_valid_next;
  logic                dm_valid_reg, dm_valid_next;
  logic [DATA_W-1:0]   if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0]   dm_rdata_reg, dm_rdata_next;
  logic [CNT_W-1:0]    fair_cnt_reg, fair_cnt_next;
  logic                if_elig, dm_elig;

  // A port whose valid is pulsing this cycle must not be re-granted on the same request.
  assign if_elig = if_req & ~if_valid_reg;
  assign dm_elig = dm_req & ~dm_valid_reg;

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_wstrb_next = mem_wstrb_reg;
    if_rdata_next  = if_rdata_reg;
    dm_rdata_next  = dm_rdata_reg;
    fair_cnt_next  = fair_cnt_reg;
    if_valid_next  = 1'b0;
    dm_valid_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dm_elig && (!if_elig || fair_cnt_reg != FAIR_MAX)) begin
          state_next     = ISSUE;
          owner_next     = 1'b1;
          mem_req_next   = 1'b1;
          mem_we_next    = dm_we;
          mem_addr_next  = dm_addr;
          mem_wdata_next = dm_wdata;
          mem_wstrb_next = dm_wstrb;
          if (if_elig && fair_cnt_reg != FAIR_MAX)
            fair_cnt_next = fair_cnt_reg + CNT_W'(1);
        end else if (if_elig) begin
          state_next     = ISSUE;
          owner_next     = 1'b0;
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b0;
          mem_addr_next  = if_addr;
          mem_wdata_next = '0;
          mem_wstrb_next = '0;
          fair_cnt_next  = '0;
        end
      end
      ISSUE: begin
        // Any response during the grant cycle is a memory protocol violation and is ignored.
        if (mem_gnt) begin
          state_next   = WAIT;
          mem_req_next = 1'b0;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_next = IDLE;
          if (owner_reg) begin
            dm_rdata_next = mem_rdata;
            dm_valid_next = 1'b1;
          end else begin
            if_rdata_next = mem_rdata;
            if_valid_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      owner_reg     <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wstrb_reg <= '0;
      if_valid_reg  <= 1'b0;
      dm_valid_reg  <= 1'b0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
      fair_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_wstrb_reg <= mem_wstrb_next;
      if_valid_reg  <= if_valid_next;
      dm_valid_reg  <= dm_valid_next;
      if_rdata_reg  <= if_rdata_next;
      dm_rdata_reg  <= dm_rdata_next;
      fair_cnt_reg  <= fair_cnt_next;
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wstrb = mem_wstrb_reg;
  assign if_valid  = if_valid_reg;
  assign dm_valid  = dm_valid_reg;
  assign if_rdata  = if_rdata_reg;
  assign dm_rdata  = dm_rdata_reg;
  assign if_busy   = if_req & ~if_valid_reg;
  assign dm_busy   = dm_req & ~dm_valid_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one linear sequence of steps with
// hand-computed expectations checked by immediate assertions.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid, if_busy;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_wstrb;
  logic        dm_valid, dm_busy;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_busy(if_busy),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_busy(dm_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are then driven and outputs sampled well clear of the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_dm_valid"}, 32'(dm_valid), 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_dm_rdata"}, dm_rdata, 32'd0);
  endtask

  initial begin
    rst = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
    dm_wdata = 0; dm_wstrb = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    step(); step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Single fetch, fastest memory: valid at t+3.
    if_req = 1; if_addr = 32'h100; #1;
    chk("f1_busy_t0", 32'(if_busy), 32'd1);
    chk("f1_noreq_t0", 32'(mem_req), 32'd0);
    step();  // t+1
    chk("f1_mem_req", 32'(mem_req), 32'd1);
    chk("f1_mem_addr", mem_addr, 32'h100);
    chk("f1_mem_we", 32'(mem_we), 32'd0);
    chk("f1_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("f1_busy_t1", 32'(if_busy), 32'd1);
    mem_gnt = 1;
    step();  // t+2
    chk("f1_req_cleared", 32'(mem_req), 32'd0);
    chk("f1_busy_t2", 32'(if_busy), 32'd1);
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00500093;
    step();  // t+3
    mem_rvalid = 0; mem_rdata = 0; #1;
    chk("f1_valid", 32'(if_valid), 32'd1);
    chk("f1_rdata", if_rdata, 32'h00500093);
    chk("f1_busy_t3", 32'(if_busy), 32'd0);
    step();  // t+4: held request must not have been re-issued
    chk("f1_no_reissue", 32'(mem_req), 32'd0);
    chk("f1_valid_pulse", 32'(if_valid), 32'd0);
    if_req = 0;
    step();

    // Store vs fetch contention: store first, fetch granted in the dm_valid cycle.
    if_req = 1; if_addr = 32'h104;
    dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF; dm_wstrb = 4'hF; #1;
    chk("c_dm_busy", 32'(dm_busy), 32'd1);
    step();  // t+1
    chk("c_st_req", 32'(mem_req), 32'd1);
    chk("c_st_we", 32'(mem_we), 32'd1);
    chk("c_st_addr", mem_addr, 32'h2000);
    chk("c_st_wdata", mem_wdata, 32'hDEADBEEF);
    chk("c_st_wstrb", 32'(mem_wstrb), 32'hF);
    mem_gnt = 1;
    step();  // t+2
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hA5A5A5A5;
    step();  // t+3
    mem_rvalid = 0; #1;
    chk("c_dm_valid", 32'(dm_valid), 32'd1);
    chk("c_if_not_valid", 32'(if_valid), 32'd0);
    chk("c_if_busy", 32'(if_busy), 32'd1);
    dm_req = 0; dm_we = 0;
    step();  // t+4
    chk("c_f_req", 32'(mem_req), 32'd1);
    chk("c_f_addr", mem_addr, 32'h104);
    chk("c_f_we", 32'(mem_we), 32'd0);
    chk("c_f_wdata", mem_wdata, 32'd0);
    chk("c_f_wstrb", 32'(mem_wstrb), 32'd0);
    chk("c_dm_pulse", 32'(dm_valid), 32'd0);
    mem_gnt = 1;
    step();  // t+5
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00A00113;
    step();  // t+6
    mem_rvalid = 0; #1;
    chk("c_if_valid", 32'(if_valid), 32'd1);
    chk("c_if_rdata", if_rdata, 32'h00A00113);
    if_req = 0;
    step();

    // Fairness: both ports request together each round (both drop in each valid cycle).
    // Counter 0..3 -> data wins four times, at 4 the fetch wins, then data again.
    for (int k = 0; k < 6; k++) begin
      logic exp_dm;
      exp_dm = (k != 4);
      if_req = 1; if_addr = 32'h200;
      dm_req = 1; dm_we = 0; dm_addr = 32'h3000 + 32'(k * 4); dm_wdata = 32'h77; dm_wstrb = 4'h0;
      step();
      chk($sformatf("fair%0d_owner_addr", k), mem_addr, exp_dm ? 32'h3000 + 32'(k * 4) : 32'h200);
      chk($sformatf("fair%0d_req", k), 32'(mem_req), 32'd1);
      mem_gnt = 1;
      step();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'(k);
      step();
      mem_rvalid = 0;
      chk($sformatf("fair%0d_dm_valid", k), 32'(dm_valid), 32'(exp_dm));
      chk($sformatf("fair%0d_if_valid", k), 32'(if_valid), 32'(!exp_dm));
      if (exp_dm) chk($sformatf("fair%0d_dm_rdata", k), dm_rdata, 32'(k));
      else        chk($sformatf("fair%0d_if_rdata", k), if_rdata, 32'(k));
      if_req = 0; dm_req = 0;
      step();
    end

    // Slow memory: gnt 3 cycles late, rvalid 5 cycles after gnt; load from data port.
    dm_req = 1; dm_we = 0; dm_addr = 32'h4000; dm_wdata = 32'h11112222; dm_wstrb = 4'h0;
    step();  // t+1
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("slow_hold_req%0d", i), 32'(mem_req), 32'd1);
      chk($sformatf("slow_hold_addr%0d", i), mem_addr, 32'h4000);
      step();
    end
    mem_gnt = 1; #1;  // t+4 is the grant cycle
    chk("slow_gnt_req", 32'(mem_req), 32'd1);
    chk("slow_gnt_wdata", mem_wdata, 32'h11112222);
    step();  // t+5
    mem_gnt = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("slow_wait_req%0d", i), 32'(mem_req), 32'd0);
      chk($sformatf("slow_wait_valid%0d", i), 32'(dm_valid), 32'd0);
      step();
    end
    mem_rvalid = 1; mem_rdata = 32'h55AA55AA;  // t+9
    step();  // t+10
    mem_rvalid = 0; #1;
    chk("slow_dm_valid", 32'(dm_valid), 32'd1);
    chk("slow_dm_rdata", dm_rdata, 32'h55AA55AA);
    chk("slow_if_rdata_held", if_rdata, 32'd4);
    dm_req = 0;
    step();

    // Reset while in WAIT, followed by a stray response.
    if_req = 1; if_addr = 32'h500;
    step();  // t+1
    chk("rst_issue_req", 32'(mem_req), 32'd1);
    mem_gnt = 1;
    step();  // t+2 (WAIT)
    mem_gnt = 0; rst = 1;
    step();  // t+3
    rst = 0; if_req = 0; mem_rvalid = 1; mem_rdata = 32'h1234; #1;
    chk_reset_outputs("rst_mid");
    step();  // t+4
    mem_rvalid = 0; mem_rdata = 0; #1;
    chk("rst_late_if_valid", 32'(if_valid), 32'd0);
    chk("rst_late_dm_valid", 32'(dm_valid), 32'd0);
    chk("rst_late_if_rdata", if_rdata, 32'd0);
    chk("rst_late_mem_req", 32'(mem_req), 32'd0);
    if_req = 1; if_addr = 32'h600;
    step();  // t+5
    chk("post_rst_req", 32'(mem_req), 32'd1);
    chk("post_rst_addr", mem_addr, 32'h600);
    mem_gnt = 1;
    step();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE;
    step();
    mem_rvalid = 0; #1;
    chk("post_rst_valid", 32'(if_valid), 32'd1);
    chk("post_rst_rdata", if_rdata, 32'hCAFE);
    if_req = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
